// File: rtl/addsub_serial_if.sv
// Operand/result handshake bundle for the chunk-serial adder/subtractor.
// master = producer/consumer side, slave = the arithmetic block.
interface addsub_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovfl;

    modport master (
        output in_valid, a, b, sub, sat, out_ready,
        input  in_ready, out_valid, sum, cout, ovfl
    );

    modport slave (
        input  in_valid, a, b, sub, sat, out_ready,
        output in_ready, out_valid, sum, cout, ovfl
    );
endinterface

// File: rtl/addsub_serial.sv
// Chunk-serial two's complement adder/subtractor: CHUNK bits per cycle, LSB chunk first,
// with optional signed saturation and a valid/ready handshake on both sides.
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst,
    addsub_serial_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_in_ready;
    logic             w_out_valid;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_sat;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovfl;
    logic [IW-1:0]    r_idx;

    int               w_base;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_chunk_sum;
    logic             w_msb_cin;
    logic             w_last;
    logic             w_ovfl;
    logic [WIDTH-1:0] w_res_full;
    logic [WIDTH-1:0] w_sat_val;

    assign w_base      = CHUNK * int'(r_idx);
    assign w_a_chunk   = r_a[w_base +: CHUNK];
    assign w_b_chunk   = r_b[w_base +: CHUNK];
    assign w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    assign w_last      = (r_idx == LAST_IDX);

    // Carry into the MSB comes from the lower CHUNK-1 bits of the final chunk.
    generate
        if (CHUNK == 1) begin : g_cin_direct
            assign w_msb_cin = r_carry;
        end else begin : g_cin_low
            logic [CHUNK-1:0] w_low;
            assign w_low = {1'b0, w_a_chunk[CHUNK-2:0]} + {1'b0, w_b_chunk[CHUNK-2:0]}
                         + {{(CHUNK-1){1'b0}}, r_carry};
            assign w_msb_cin = w_low[CHUNK-1];
        end
    endgenerate

    assign w_ovfl    = w_msb_cin ^ w_chunk_sum[CHUNK];
    assign w_sat_val = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

    always_comb begin
        w_res_full = r_res;
        w_res_full[w_base +: CHUNK] = w_chunk_sum[CHUNK-1:0];
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_next = RUN;
            end
            RUN: begin
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_sat   <= 1'b0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovfl  <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_sat   <= bus.sat;
                        r_carry <= bus.sub;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_res   <= w_res_full;
                    r_carry <= w_chunk_sum[CHUNK];
                    r_idx   <= r_idx + 1'b1;
                    // Visible result only changes once the whole word is known.
                    if (w_last) begin
                        r_sum  <= (r_sat && w_ovfl) ? w_sat_val : w_res_full;
                        r_cout <= w_chunk_sum[CHUNK];
                        r_ovfl <= w_ovfl;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovfl      = r_ovfl;
endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench: 16/4 instance driven from a vector table plus backpressure and reset
// sequences, 8/8 instance checked against a reference model on random back-to-back operations.
module tb_addsub_serial;
    logic clk;
    logic rst;

    addsub_serial_if #(.WIDTH(16)) if16 ();
    addsub_serial_if #(.WIDTH(8))  if8 ();

    addsub_serial #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    addsub_serial #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovfl;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        sat;
        logic [15:0] sum;
        logic        cout;
        logic        ovfl;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[12];
    int   n_vec = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic exp_t ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                       input logic sub, input logic sat);
        exp_t        e;
        logic [15:0] mask;
        logic [15:0] bb;
        logic [16:0] full;
        logic        am;
        mask   = (w == 16) ? 16'hFFFF : 16'h00FF;
        bb     = (sub ? ~b : b) & mask;
        full   = {1'b0, a & mask} + {1'b0, bb} + {16'h0, sub};
        am     = a[w-1];
        e.cout = full[w];
        e.ovfl = (am == bb[w-1]) && (full[w-1] != am);
        e.sum  = full[15:0] & mask;
        if (sat && e.ovfl) e.sum = am ? (16'h1 << (w - 1)) : (mask >> 1);
        return e;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic sat);
        if (sel) begin
            if8.in_valid = v; if8.a = a[7:0]; if8.b = b[7:0]; if8.sub = sub; if8.sat = sat;
        end else begin
            if16.in_valid = v; if16.a = a; if16.b = b; if16.sub = sub; if16.sat = sat;
        end
    endtask

    function automatic logic get_in_ready(input bit sel);
        return sel ? if8.in_ready : if16.in_ready;
    endfunction

    function automatic logic get_out_valid(input bit sel);
        return sel ? if8.out_valid : if16.out_valid;
    endfunction

    function automatic logic get_out_ready(input bit sel);
        return sel ? if8.out_ready : if16.out_ready;
    endfunction

    function automatic exp_t get_result(input bit sel);
        exp_t r;
        r.sum  = sel ? {8'h00, if8.sum} : if16.sum;
        r.cout = sel ? if8.cout : if16.cout;
        r.ovfl = sel ? if8.ovfl : if16.ovfl;
        return r;
    endfunction

    // One operation: accept, latency check, scoreboard compare; steps back to IDLE if out_ready.
    task automatic run_op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic sat, input exp_t e);
        int   cyc;
        exp_t exp_r;
        exp_t got;
        cyc = 0;
        while (!get_in_ready(sel) && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check("in_ready_before_accept", 32'(get_in_ready(sel)), 32'd1);
        drive(sel, 1'b1, a, b, sub, sat);
        sb_q.push_back(e);
        @(posedge clk); #1;
        drive(sel, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        check("in_ready_busy", 32'(get_in_ready(sel)), 32'd0);
        cyc = 0;
        while (!get_out_valid(sel) && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check("latency", 32'(cyc), sel ? 32'd1 : 32'd4);
        exp_r = sb_q.pop_front();
        got   = get_result(sel);
        $display("op w=%0d a=%h b=%h sub=%0d sat=%0d -> sum=%h cout=%0d ovfl=%0d (exp %h %0d %0d)",
                 sel ? 8 : 16, a, b, sub, sat, got.sum, got.cout, got.ovfl,
                 exp_r.sum, exp_r.cout, exp_r.ovfl);
        check("sum", 32'(got.sum), 32'(exp_r.sum));
        check("cout", 32'(got.cout), 32'(exp_r.cout));
        check("ovfl", 32'(got.ovfl), 32'(exp_r.ovfl));
        if (get_out_ready(sel)) begin @(posedge clk); #1; end
    endtask

    initial begin
        exp_t e;
        int   hits;
        vecs[0]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1};
        vecs[2]  = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1};
        vecs[4]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
        vecs[8]  = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b1};
        vecs[9]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        if16.out_ready = 1'b1;
        if8.out_ready  = 1'b1;
        #23;
        check("rst_in_ready", 32'(if16.in_ready), 32'd1);
        check("rst_out_valid", 32'(if16.out_valid), 32'd0);
        check("rst_sum", 32'(if16.sum), 32'd0);
        check("rst_flags", {30'h0, if16.cout, if16.ovfl}, 32'd0);
        check("rst8_out_valid", 32'(if8.out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            e.sum = vecs[i].sum; e.cout = vecs[i].cout; e.ovfl = vecs[i].ovfl;
            run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sat, e);
        end

        // Backpressure: result must hold while the consumer stalls.
        if16.out_ready = 1'b0;
        e = '{16'h5555, 1'b0, 1'b0};
        run_op(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0, e);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_sum", 32'(if16.sum), 32'h5555);
            check("bp_in_ready", 32'(if16.in_ready), 32'd0);
            check("bp_out_valid", 32'(if16.out_valid), 32'd1);
        end
        if16.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", 32'(if16.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(if16.in_ready), 32'd1);
        $display("seq backpressure done");

        // Reset two cycles into a run: abort immediately, never present the result.
        drive(1'b0, 1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(if16.out_valid), 32'd0);
        check("abort_in_ready", 32'(if16.in_ready), 32'd1);
        check("abort_sum", 32'(if16.sum), 32'd0);
        check("abort_flags", {30'h0, if16.cout, if16.ovfl}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (if16.out_valid) hits++;
        end
        check("abort_no_result", 32'(hits), 32'd0);
        $display("seq reset abort done");
        e = '{16'h0000, 1'b1, 1'b0};
        run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, e);

        // Single-chunk configuration.
        e = '{16'h0000, 1'b1, 1'b1};
        run_op(1'b1, 16'h0080, 16'h0080, 1'b0, 1'b0, e);
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rs;
            logic        rt;
            ra = {8'h00, 8'($urandom)};
            rb = {8'h00, 8'($urandom)};
            rs = 1'($urandom);
            rt = 1'($urandom);
            run_op(1'b1, ra, rb, rs, rt, ref_model(8, ra, rb, rs, rt));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
